// File: rtl/inv_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// inv_mix_columns_seq
//   Sequential AES InvMixColumns stage. A 128-bit state is accepted and then
//   transformed one column per clock, in place, over four BUSY cycles. The
//   result is then offered downstream through a valid/ready handshake. A result
//   handshake and a new input handshake can happen on the same edge, so the
//   next state starts without an IDLE bubble (one state per 5 cycles).
//
//   Byte ordering: byte k = state[127-8k -: 8]; column c = bytes 4c..4c+3;
//   column 0 = [127:96]; row 0 is the most significant byte of a column.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    upstream state available
//   in_ready   out  1    block can accept a state this cycle
//   in_state   in   128  input state
//   out_valid  out  1    out_state holds a completed result
//   out_ready  in   1    downstream accepts the result
//   out_state  out  128  transformed state (same byte ordering)
//   busy       out  1    high while columns are being transformed
// -----------------------------------------------------------------------------
module inv_mix_columns_seq (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_fsm;
   state_t        w_fsm_nxt;
   logic [1:0]    r_col;
   logic [127:0]  r_state;
   logic [127:0]  r_out;
   logic [31:0]   w_col_in;
   logic [31:0]   w_col_out;
   logic [127:0]  w_state_upd;
   logic          w_accept;

   // ---------------------------------------------------------------------------
   // GF(2^8) constant multipliers (AES polynomial x^8+x^4+x^3+x+1)
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] m9(input logic [7:0] a);
      logic [7:0] x2, x4, x8;
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      return x8 ^ a;
   endfunction

   function automatic logic [7:0] m11(input logic [7:0] a);
      logic [7:0] x2, x4, x8;
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      return x8 ^ x2 ^ a;
   endfunction

   function automatic logic [7:0] m13(input logic [7:0] a);
      logic [7:0] x2, x4, x8;
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      return x8 ^ x4 ^ a;
   endfunction

   function automatic logic [7:0] m14(input logic [7:0] a);
      logic [7:0] x2, x4, x8;
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      return x8 ^ x4 ^ x2;
   endfunction

   // One InvMixColumns column: circulant matrix {0e,0b,0d,09}.
   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      b0 = m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3);
      b1 = m9(a0)  ^ m14(a1) ^ m11(a2) ^ m13(a3);
      b2 = m13(a0) ^ m9(a1)  ^ m14(a2) ^ m11(a3);
      b3 = m11(a0) ^ m13(a1) ^ m9(a2)  ^ m14(a3);
      return {b0, b1, b2, b3};
   endfunction

   // ---------------------------------------------------------------------------
   // Column datapath: select column r_col, transform, write back in place
   // ---------------------------------------------------------------------------
   always_comb begin
      w_col_in = r_state[127:96];
      case (r_col)
         2'd0: w_col_in = r_state[127:96];
         2'd1: w_col_in = r_state[95:64];
         2'd2: w_col_in = r_state[63:32];
         2'd3: w_col_in = r_state[31:0];
         default: w_col_in = r_state[127:96];
      endcase
   end

   assign w_col_out = inv_col(w_col_in);

   always_comb begin
      w_state_upd = r_state;
      case (r_col)
         2'd0: w_state_upd[127:96] = w_col_out;
         2'd1: w_state_upd[95:64]  = w_col_out;
         2'd2: w_state_upd[63:32]  = w_col_out;
         2'd3: w_state_upd[31:0]   = w_col_out;
         default: w_state_upd = r_state;
      endcase
   end

   assign w_accept = in_valid & in_ready;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm <= S_IDLE;
      end else begin
         r_fsm <= w_fsm_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         S_IDLE: begin
            if (w_accept) w_fsm_nxt = S_BUSY;
         end
         S_BUSY: begin
            if (r_col == 2'd3) w_fsm_nxt = S_DONE;
         end
         S_DONE: begin
            // Result handshake; a simultaneous new input skips IDLE.
            if (out_ready) w_fsm_nxt = w_accept ? S_BUSY : S_IDLE;
         end
         default: w_fsm_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (r_fsm)
         S_IDLE: in_ready = 1'b1;
         S_BUSY: busy     = 1'b1;
         S_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: in_ready = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Working state, column counter and held result
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col   <= 2'd0;
         r_state <= '0;
         r_out   <= '0;
      end else if (w_accept) begin
         r_state <= in_state;
         r_col   <= 2'd0;
      end else if (r_fsm == S_BUSY) begin
         r_state <= w_state_upd;
         r_col   <= r_col + 2'd1;
         // Result register only changes on completion, so out_state stays
         // stable through DONE and afterwards until the next result.
         if (r_col == 2'd3) r_out <= w_state_upd;
      end
   end

   assign out_state = r_out;

endmodule
